// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Pad-side companion of the GPIO register block.
//   - Decodes the 2-bit per-pin mode from reg_ctrl and drives registered
//     pad output value (io_out) and output enable (io_oe).
//   - Conditions raw pad inputs through a two-flop synchronizer and, when
//     built with the GPIO_PAD_DEBOUNCE_EN macro, a per-pin debounce filter.
//     The conditioned level is returned on io_pin_o.
//   - Latches filtered edges of input-mode pins into sticky pending bits and
//     raises a level interrupt (OR of pending bits).
//
// Configuration macro: GPIO_PAD_DEBOUNCE_EN
//   defined   : per-pin debounce counters, DEBOUNCE_CYCLES stable cycles
//   undefined : filtered level follows the synchronizer every cycle
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   reg_ctrl   : GPIO control register, 2 bits per pin
//                (00 Hi-Z, 01 output, 10 input, 11 reserved = Hi-Z)
//   reg_data   : GPIO data register, bit i = output value of pin i
//   io_in      : raw asynchronous pad input
//   io_out     : pad output value
//   io_oe      : pad output enable, 1 = drive
//   io_pin_o   : conditioned input level toward the GPIO block
//   irq_clr_i  : write-1-to-clear strobe for pending bits
//   irq_pend_o : sticky edge-pending bits
//   irq_o      : OR of pending bits

module gpio_pad_ctrl #(
  parameter int GPIO_NUM        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] reg_ctrl,
  input  logic [31:0] reg_data,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic [15:0] io_oe,
  output logic [15:0] io_pin_o,
  input  logic [15:0] irq_clr_i,
  output logic [15:0] irq_pend_o,
  output logic        irq_o
);

  // Pins at or above GPIO_NUM are held at 0 in every register.
  localparam logic [31:0] PIN_MASK_W = (32'h1 << GPIO_NUM) - 32'h1;
  localparam logic [15:0] PIN_MASK   = PIN_MASK_W[15:0];

  logic [15:0] out_next;
  logic [15:0] oe_next;
  logic [15:0] in_mode;
  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] filt;
  logic [15:0] filt_next;
  logic [15:0] pend;
  logic [15:0] pend_set;
  logic [15:0] out_q;
  logic [15:0] oe_q;

  // Upper data bits have no pin to drive.
  logic unused_data;
  assign unused_data = ^reg_data[31:16];

  always_comb begin
    out_next = '0;
    oe_next  = '0;
    in_mode  = '0;
    for (int i = 0; i < 16; i++) begin
      oe_next[i]  = (reg_ctrl[2*i +: 2] == 2'b01);
      out_next[i] = (reg_ctrl[2*i +: 2] == 2'b01) & reg_data[i];
      in_mode[i]  = (reg_ctrl[2*i +: 2] == 2'b10);
    end
    out_next = out_next & PIN_MASK;
    oe_next  = oe_next & PIN_MASK;
    in_mode  = in_mode & PIN_MASK;
  end

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt      [16];
  logic [CNT_W-1:0] cnt_next [16];

  // Accept a new level only after it has differed from filt for
  // DEBOUNCE_CYCLES consecutive cycles; any return to filt restarts the count.
  always_comb begin
    filt_next = filt;
    for (int i = 0; i < 16; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == filt[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        filt_next[i] = s2[i];
        cnt_next[i]  = '0;
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (!rst_n) cnt[i] <= '0;
      else        cnt[i] <= cnt_next[i];
    end
  end
`else
  logic [31:0] unused_dbc;
  assign unused_dbc = DEBOUNCE_CYCLES;
  assign filt_next  = s2;
`endif

  // A pending bit sets on any filtered edge of an input-mode pin; the set
  // term is OR'd after the clear so a coincident edge is never lost.
  assign pend_set = (filt_next ^ filt) & in_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      filt  <= '0;
      pend  <= '0;
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      s1    <= io_in & PIN_MASK;
      s2    <= s1;
      filt  <= filt_next;
      pend  <= ((pend & ~irq_clr_i) | pend_set) & PIN_MASK;
      out_q <= out_next;
      oe_q  <= oe_next;
    end
  end

  assign io_out     = out_q;
  assign io_oe      = oe_q;
  assign io_pin_o   = filt;
  assign irq_pend_o = pend;
  assign irq_o      = |pend;

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Pad-side companion of the GPIO register block. Consumes the GPIO control and data registers to drive per-pin output value and output-enable, and conditions raw pad inputs through a synchronizer and an optional debounce filter before returning them as the GPIO block's `io_pin_i`. Also latches input edges into sticky pending bits and raises a level interrupt toward the core.

## Interface

**Parameters**
- `GPIO_NUM`, default 16: number of pins; must be 1..16.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a new input level; must be ≥1. Used only with `GPIO_PAD_DEBOUNCE_EN`.

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `reg_ctrl`, input, 32: GPIO control register; 2 bits per pin.
- `reg_data`, input, 32: GPIO data register; bit i is the output value of pin i.
- `io_in`, input, 16: raw asynchronous pad input.
- `io_out`, output, 16: pad output value.
- `io_oe`, output, 16: pad output enable; 1 = drive.
- `io_pin_o`, output, 16: conditioned input level, wired to GPIO `io_pin_i`.
- `irq_clr_i`, input, 16: write-1-to-clear strobe for pending bits; 1-cycle pulse per bit.
- `irq_pend_o`, output, 16: sticky edge-pending bits.
- `irq_o`, output, 1: OR of `irq_pend_o`.

## Operation

- **Mode decode per pin i:** `m = reg_ctrl[2i+1:2i]`.
  - 00 (Hi-Z): `oe=0`, `out=0`.
  - 01 (output): `oe=1`, `out=reg_data[i]`.
  - 10 (input): `oe=0`, `out=0`.
  - 11 (reserved): treated as Hi-Z.
- `io_out`/`io_oe` are registered.
- Bits at or above `GPIO_NUM` are tied to 0 on every output.
- **Input path per pin:**
  - Two-flop synchronizer `s1 → s2`.
  - A filtered register `filt[i]` drives `io_pin_o[i]`.
  - The input path runs in all modes, so `io_pin_o` always reflects the pad.
- **Debounce (when enabled):**
  - Per-pin counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2==filt`: `cnt` ← 0.
  - Else if `cnt==DEBOUNCE_CYCLES-1`: `filt` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never reaches `filt`.
  - The counter saturates logically: it never wraps past `DEBOUNCE_CYCLES-1`.
- **Edge pending:**
  - On a cycle where `filt[i]` changes and pin i is in mode 10, `pend[i]` ← 1. Both rising and falling edges count.
  - `irq_clr_i[i]=1` clears `pend[i]`.
  - If set and clear occur in the same cycle, set wins.
  - Changing a pin's mode leaves its pending bit unchanged.
- `irq_o` is combinational OR of `pend`. There is no glitch path from inputs.

## Timing

- **Reset:** all of the following are 0 on the edge where `rst_n=0`: `s1`, `s2`, `filt`, `cnt`, `pend`, `io_out`, `io_oe`.
  - Consequently `io_pin_o`, `irq_pend_o`, and `irq_o` are 0.
  - Reset mid-debounce discards partial counts.
- **Output latency:** a `reg_ctrl`/`reg_data` change visible before edge k appears on `io_out`/`io_oe` after edge k (1 cycle).
- **Input latency:** `io_in` change sampled at edge k gives `s2` valid after k+1. `filt`/`io_pin_o` then update after edge:
  - without debounce: k+2;
  - with debounce: k+1+`DEBOUNCE_CYCLES` (equals k+2 when `DEBOUNCE_CYCLES=1`).
- `pend` sets on the same edge as `filt` changes; `irq_o` is high in the same cycle.
- Clear takes effect on the edge where `irq_clr_i` is sampled high.
- The GPIO block captures `io_pin_o` one further cycle later. That cycle is not this block's concern.

## Configuration

- **Macro:** `GPIO_PAD_DEBOUNCE_EN`.
- **Defined:** per-pin debounce counters are present, with the timing above.
- **Undefined:**
  - No counters are instantiated.
  - `filt` ← `s2` every cycle.
  - `DEBOUNCE_CYCLES` is ignored.
  - Input latency is fixed at 2 edges after sampling.

## Test plan

- **Reset:** assert `rst_n=0` with `io_in=16'hFFFF` and `reg_ctrl=32'h5555_5555`. Required: all outputs 0 during reset. After release, `io_oe=16'hFFFF` one cycle later.
- **Output drive:** `reg_ctrl=32'h0000_0005`, `reg_data=32'h3`.
  - Required: `io_oe=16'h0003`, `io_out=16'h0003` after 1 edge.
  - Then set `reg_ctrl[1:0]=2'b11`: `io_oe[0]=0`, `io_out[0]=0`.
- **Input latency and edge irq:** pin 2 in mode 10, `DEBOUNCE_CYCLES=4`, debounce on; raise `io_in[2]` at edge k.
  - Required: `io_pin_o[2]=1` and `irq_pend_o=16'h0004` after edge k+5; `irq_o=1`.
  - Repeat with debounce off: same results after edge k+2.
- **Glitch rejection (debounce on):** a 3-cycle high pulse on `io_in[2]`. Required: `io_pin_o[2]` stays 0 and `irq_o` stays 0. A 4-cycle pulse is accepted.
- **Clear vs set collision:** pulse `irq_clr_i[2]=1` on the same edge a new falling edge updates `filt[2]`. Required: `pend[2]` remains 1. A later clear with no edge gives `pend[2]=0` and `irq_o=0`.
- **Mode gating:** pin 3 in mode 01 (output); toggle `io_in[3]`. Required: `io_pin_o[3]` follows after the latency above, and `pend[3]` stays 0.
